// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue onto one fixed-latency ALU,
// with a tag shadow pipeline that routes results back and drops flushed ones.
module alu_issue_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PKT_W   = 64,
  parameter int RES_W   = 32,
  parameter int LAT     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PKT_W-1:0] req_pkt,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       flush,
  output logic                     alu_in_valid,
  output logic [PKT_W-1:0]         alu_in_pkt,
  input  logic                     alu_out_valid,
  input  logic [RES_W-1:0]         alu_out_res,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [RES_W-1:0]         resp_res,
  output logic                     err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = $clog2(LAT + 2);

  typedef logic [PKT_W-1:0] alu_in_pkt_t;

  logic [IDW-1:0] rr;
  logic [IDW-1:0] rr_nxt;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] cand;
  logic           hs;
  logic [NUM_REQ-1:0] elig;
  alu_in_pkt_t    win_pkt;

  logic [LAT:0]   tag_v;
  logic [LAT:0]   tag_k;
  logic [IDW-1:0] tag_id [LAT+1];
  logic [SW-1:0]  sup;
  logic           tail_v;
  logic           ret;

  assign elig = req_valid & ~flush;

  // first eligible requester at or after rr, wrapping
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    cand      = '0;
    hs        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr) + k) % NUM_REQ);
      if (!hs && elig[cand]) begin
        hs              = 1'b1;
        gnt_id          = cand;
        req_ready[cand] = 1'b1;
      end
    end
  end

  assign rr_nxt  = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  assign win_pkt = req_pkt[gnt_id*PKT_W +: PKT_W];

  // a flush arriving with the result still kills it
  assign tail_v = tag_v[LAT];
  assign ret    = alu_out_valid & tail_v & ~tag_k[LAT]
                & ~flush[tag_id[LAT]];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr           <= '0;
      alu_in_valid <= 1'b0;
      alu_in_pkt   <= '0;
      resp_valid   <= '0;
      resp_res     <= '0;
      err          <= 1'b0;
      sup          <= SW'(LAT + 1);
      tag_v        <= '0;
      tag_k        <= '0;
      for (int j = 0; j <= LAT; j++) tag_id[j] <= '0;
    end else begin
      alu_in_valid <= hs;
      if (hs) begin
        alu_in_pkt <= win_pkt;
        rr         <= rr_nxt;
      end
      tag_v     <= {tag_v[LAT-1:0], hs};
      tag_k[0]  <= hs & flush[gnt_id];
      tag_id[0] <= gnt_id;
      for (int j = 1; j <= LAT; j++) begin
        tag_k[j]  <= tag_k[j-1]
                   | (tag_v[j-1] & flush[tag_id[j-1]]);
        tag_id[j] <= tag_id[j-1];
      end
      resp_valid <= '0;
      if (ret) begin
        resp_valid[tag_id[LAT]] <= 1'b1;
        resp_res                <= alu_out_res;
      end
      // stale ALU results after reset are not protocol errors
      if (sup != '0) sup <= sup - 1'b1;
      else if (alu_out_valid != tail_v) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: scoreboard bench with a behavioural
// fixed-latency ALU and a reference round-robin model.
module tb_alu_issue_arbiter;

  localparam int N   = 2;
  localparam int PW  = 64;
  localparam int RW  = 32;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_pkt;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    flush;
  logic            alu_in_valid;
  logic [PW-1:0]   alu_in_pkt;
  logic            alu_out_valid;
  logic [RW-1:0]   alu_out_res;
  logic [N-1:0]    resp_valid;
  logic [RW-1:0]   resp_res;
  logic            err;

  always #5 clk = ~clk;

  alu_issue_arbiter #(
    .NUM_REQ(N), .PKT_W(PW), .RES_W(RW), .LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_pkt(req_pkt),
    .req_ready(req_ready),
    .flush(flush),
    .alu_in_valid(alu_in_valid),
    .alu_in_pkt(alu_in_pkt),
    .alu_out_valid(alu_out_valid),
    .alu_out_res(alu_out_res),
    .resp_valid(resp_valid),
    .resp_res(resp_res),
    .err(err)
  );

  typedef struct {
    int          id;
    logic [RW-1:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int post  = -1;
  int m_rr  = 0;
  logic          exp_iv   = 1'b0;
  logic [PW-1:0] exp_pkt  = '0;
  logic          exp_err  = 1'b0;
  logic          err_pend = 1'b0;
  logic          pv [LAT+1];
  logic [PW-1:0] pp [LAT+1];

  function automatic logic [RW-1:0] alu_fn(input logic [PW-1:0] p);
    return p[RW-1:0] ^ p[PW-1:PW-RW] ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc_n, got, exp);
    end
  endtask

  task automatic tick(input logic [N-1:0] v, input logic [N-1:0] fl,
                      input logic rst, input logic spur,
                      input logic drop, input logic [PW-1:0] p0);
    int           g;
    logic         due_now;
    logic [N-1:0] er;
    @(posedge clk);
    #1;
    cyc_n++;
    post++;
    exp_err  = exp_err | err_pend;
    err_pend = 1'b0;
    for (int j = LAT; j > 0; j--) begin
      pv[j] = pv[j-1];
      pp[j] = pp[j-1];
    end
    pv[0] = alu_in_valid;
    pp[0] = alu_in_pkt;

    chk("alu_in_valid", 64'(alu_in_valid), 64'(exp_iv));
    chk("alu_in_pkt", 64'(alu_in_pkt), 64'(exp_pkt));
    chk("err", 64'(err), 64'(exp_err));
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      chk("resp_valid", 64'(resp_valid), 64'd1 << sb[0].id);
      chk("resp_res", 64'(resp_res), 64'(sb[0].res));
      void'(sb.pop_front());
    end else begin
      chk("resp_idle", 64'(resp_valid), 64'd0);
    end
    due_now = (sb.size() > 0) && (sb[0].due == cyc_n + 1);

    alu_out_valid = (pv[LAT] & ~drop) | spur;
    alu_out_res   = alu_fn(pp[LAT]);
    reset     = rst;
    req_valid = v;
    flush     = fl;
    for (int i = 0; i < N; i++) req_pkt[i*PW +: PW] = {$urandom, $urandom};
    if (p0 != '0) req_pkt[PW-1:0] = p0;
    #1;

    er = v & ~fl;
    g  = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && er[(m_rr + k) % N]) g = (m_rr + k) % N;
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));

    if (rst) begin
      sb.delete();
      m_rr     = 0;
      exp_iv   = 1'b0;
      exp_pkt  = '0;
      exp_err  = 1'b0;
      err_pend = 1'b0;
      post     = -1;
    end else begin
      if (post > LAT && ((spur && !due_now) || (drop && due_now)))
        err_pend = 1'b1;
      if (drop && due_now) void'(sb.pop_front());
      for (int i = sb.size() - 1; i >= 0; i--)
        if (fl[sb[i].id]) sb.delete(i);
      exp_iv = (g >= 0);
      if (g >= 0) begin
        exp_pkt = req_pkt[g*PW +: PW];
        sb.push_back('{g, alu_fn(req_pkt[g*PW +: PW]), cyc_n + LAT + 2});
        m_rr = (g + 1) % N;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick('0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic go(input logic [N-1:0] v, input logic [N-1:0] fl);
    tick(v, fl, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rst_cyc();
    tick('0, '0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [N-1:0] rv;
    logic [N-1:0] rf;
    for (int j = 0; j <= LAT; j++) begin
      pv[j] = 1'b0;
      pp[j] = '0;
    end
    reset         = 1'b1;
    req_valid     = '0;
    req_pkt       = '0;
    flush         = '0;
    alu_out_valid = 1'b0;
    alu_out_res   = '0;
    rst_cyc();
    rst_cyc();

    // flush masks requester 0 while rr=0
    go(2'b11, 2'b01);
    idle(6);

    // single request with a fixed packet
    tick(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 64'h1234);
    idle(6);

    // fairness
    repeat (8) go(2'b11, 2'b00);
    idle(6);

    // flush in flight
    go(2'b10, 2'b00);
    go(2'b10, 2'b00);
    go(2'b01, 2'b10);
    idle(6);

    // random traffic with occasional flushes
    for (int i = 0; i < 60; i++) begin
      rv = N'($urandom_range(0, (1 << N) - 1));
      rf = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      go(rv, rf);
    end
    idle(6);

    // reset with operations in flight
    repeat (3) go(2'b11, 2'b00);
    rst_cyc();
    idle(6);
    go(2'b11, 2'b00);
    idle(6);

    // spurious ALU result
    idle(20);
    tick('0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle(4);

    // missing ALU result
    rst_cyc();
    idle(4);
    go(2'b01, 2'b00);
    idle(LAT);
    tick('0, '0, 1'b0, 1'b0, 1'b1, '0);
    idle(4);

    rst_cyc();
    idle(4);
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
